// File: rtl/parallel_bus_pollable_memory_if.sv
// ---------------------------------------------------------------------------
// parallel_bus_pollable_memory_if
//
// Purpose: handshake and control lines of the Raspberry Pi style parallel bus.
//          The bidirectional data bus is a plain module pin on the slave.
//
// Signals:
//   read             master -> slave  1 = read, 0 = write
//   register_select  master -> slave  0 = address chunk, 1 = data chunk
//   enable           master -> slave  1 = transaction active
//   ack_valid        slave  -> master handshake acknowledge
// ---------------------------------------------------------------------------
interface parallel_bus_pollable_memory_if;
    logic read;
    logic register_select;
    logic enable;
    logic ack_valid;

    modport master (
        output read,
        output register_select,
        output enable,
        input  ack_valid
    );

    modport slave (
        input  read,
        input  register_select,
        input  enable,
        output ack_valid
    );
endinterface

// File: rtl/parallel_bus_pollable_memory.sv
// ---------------------------------------------------------------------------
// parallel_bus_pollable_memory
//
// Purpose: slave side of an asynchronous 4-phase parallel bus fronting a
//          block RAM. The master writes a multi-chunk address, then writes or
//          reads a multi-chunk data word, most significant chunk first.
//
// Ports:
//   clock      in     system clock, all logic on rising edge
//   reset_n    in     asynchronous active-low reset
//   bus        inout  BUS_WIDTH shared data bus, driven while raw read = 1
//   bus_if     slave  read / register_select / enable / ack_valid
//   leds       out    [7]ack_valid [6]write_strobe [5]error [4]~reset_n
//                     [3]register_select [2]read [1]enable [0]init
//
// Build option: define PARALLEL_BUS_ERROR_COUNT_EN to add a 32-bit counter of
// address words that arrived while a data word was only partly transferred;
// leds[5] then shows a non-zero count. Without it leds[5] is tied low.
//
// Per-type chunk state (address / write / read each have their own):
//   state    | meaning
//   ST_IDLE  | waiting for the next chunk of this type
//   ST_BUSY  | chunk handled for the current enable pulse
//   ST_DONE  | last chunk of the word handled, index rewinds next clock
// ---------------------------------------------------------------------------
module parallel_bus_pollable_memory #(
    parameter int BUS_WIDTH                     = 8,
    parameter int TRANSACTIONS_PER_DATA_WORD    = 2,
    parameter int TRANSACTIONS_PER_ADDRESS_WORD = 2,
    parameter int ADDRESS_DEPTH                 = 14
) (
    input  logic                          clock,
    input  logic                          reset_n,
    inout  wire  [BUS_WIDTH-1:0]          bus,
    parallel_bus_pollable_memory_if.slave bus_if,
    output logic [7:0]                    leds
);

    localparam int TPD = TRANSACTIONS_PER_DATA_WORD;
    localparam int TPA = TRANSACTIONS_PER_ADDRESS_WORD;
    localparam int DIW = (TPD > 1) ? $clog2(TPD) : 1;
    localparam int AIW = (TPA > 1) ? $clog2(TPA) : 1;
    localparam int AW  = TPA * BUS_WIDTH;

    localparam logic [DIW-1:0] D_LAST = DIW'(TPD - 1);
    localparam logic [AIW-1:0] A_LAST = AIW'(TPA - 1);

    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_BUSY = 2'b01;
    localparam logic [1:0] ST_DONE = 2'b10;

    // synchronisers
    logic [1:0]           rd_sync;
    logic [1:0]           rs_sync;
    logic [2:0]           en_sync;
    logic [BUS_WIDTH-1:0] bus_sync1;
    logic [BUS_WIDTH-1:0] bus_s;
    logic                 rd_s;
    logic                 rs_s;
    logic                 en_s;

    // power-up hold-off
    logic [3:0] init_cnt;
    logic       init;

    // chunk sequencing
    logic [1:0]                          astate;
    logic [1:0]                          wstate;
    logic [1:0]                          rstate;
    logic [AIW-1:0]                      aword;
    logic [DIW-1:0]                      wword;
    logic [DIW-1:0]                      rword;
    logic [ADDRESS_DEPTH-1:0]            ram_addr;
    logic [TPD-1:0][BUS_WIDTH-1:0]       wdata_chunks;
    logic [BUS_WIDTH-1:0]                out_reg;
    logic                                write_strobe;
    logic                                addr_done;

    // acknowledge pipeline
    logic ack_pre;
    logic ack_d1;
    logic ack_q;

    // memory
    logic [TPD-1:0][BUS_WIDTH-1:0] mem [2**ADDRESS_DEPTH];
    logic [TPD-1:0][BUS_WIDTH-1:0] ram_q;

    logic error_led;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rd_sync   <= '0;
            rs_sync   <= '0;
            en_sync   <= '0;
            bus_sync1 <= '0;
            bus_s     <= '0;
        end else begin
            rd_sync   <= {rd_sync[0], bus_if.read};
            rs_sync   <= {rs_sync[0], bus_if.register_select};
            en_sync   <= {en_sync[1:0], bus_if.enable};
            bus_sync1 <= bus;
            bus_s     <= bus_sync1;
        end
    end

    assign rd_s = rd_sync[1];
    assign rs_s = rs_sync[1];
    assign en_s = en_sync[2];

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            init_cnt <= 4'd9;
        end else if (init_cnt != 4'd0) begin
            init_cnt <= init_cnt - 4'd1;
        end
    end

    assign init = (init_cnt != 4'd0);

    // The final address chunk retires in the clock enable is seen low.
    assign addr_done = !init && !en_s && (astate == ST_BUSY) && (aword == '0);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            astate       <= ST_IDLE;
            wstate       <= ST_IDLE;
            rstate       <= ST_IDLE;
            aword        <= A_LAST;
            wword        <= D_LAST;
            rword        <= D_LAST;
            ram_addr     <= '0;
            wdata_chunks <= '0;
            out_reg      <= '0;
            write_strobe <= 1'b0;
        end else begin
            write_strobe <= 1'b0;
            if (!init) begin
                if (en_s) begin
                    if (rd_s) begin
                        if (rstate != ST_BUSY) begin
                            out_reg <= ram_q[rword];
                            rstate  <= ST_BUSY;
                        end
                    end else if (rs_s) begin
                        if (wstate != ST_BUSY) begin
                            wdata_chunks[wword] <= bus_s;
                            wstate              <= ST_BUSY;
                        end
                    end else begin
                        if (astate != ST_BUSY) begin
                            // only the address bits that index the RAM are kept
                            for (int i = 0; i < ADDRESS_DEPTH; i++) begin
                                if (i < AW && aword == AIW'(i / BUS_WIDTH)) begin
                                    ram_addr[i] <= bus_s[i % BUS_WIDTH];
                                end
                            end
                            astate <= ST_BUSY;
                        end
                    end
                end else begin
                    case (astate)
                        ST_DONE: begin
                            astate <= ST_IDLE;
                            aword  <= A_LAST;
                        end
                        ST_BUSY: begin
                            if (aword != '0) begin
                                aword  <= aword - 1'b1;
                                astate <= ST_IDLE;
                            end else begin
                                astate <= ST_DONE;
                            end
                        end
                        default: ;
                    endcase

                    case (wstate)
                        ST_DONE: begin
                            wstate <= ST_IDLE;
                            wword  <= D_LAST;
                        end
                        ST_BUSY: begin
                            if (wword != '0) begin
                                wword  <= wword - 1'b1;
                                wstate <= ST_IDLE;
                            end else begin
                                wstate       <= ST_DONE;
                                write_strobe <= 1'b1;
                            end
                        end
                        default: ;
                    endcase

                    case (rstate)
                        ST_DONE: begin
                            rstate <= ST_IDLE;
                            rword  <= D_LAST;
                        end
                        ST_BUSY: begin
                            if (rword != '0) begin
                                rword  <= rword - 1'b1;
                                rstate <= ST_IDLE;
                            end else begin
                                rstate <= ST_DONE;
                            end
                        end
                        default: ;
                    endcase

                    // a fresh address abandons any half-finished data word
                    if (addr_done) begin
                        wword  <= D_LAST;
                        rword  <= D_LAST;
                        wstate <= ST_IDLE;
                        rstate <= ST_IDLE;
                    end
                end
            end
        end
    end

    // RAM is written the clock after the strobe, while the chunk regs still
    // hold the assembled word; reads are registered every clock.
    always_ff @(posedge clock) begin
        if (write_strobe) begin
            mem[ram_addr] <= wdata_chunks;
        end
        ram_q <= mem[ram_addr];
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ack_pre <= 1'b0;
            ack_d1  <= 1'b0;
            ack_q   <= 1'b0;
        end else begin
            ack_pre <= en_s & ~init;
            ack_d1  <= ack_pre;
            ack_q   <= ack_d1;
        end
    end

    assign bus_if.ack_valid = ack_q;

    // raw read steers the pins so the bus turns around without sync delay
    assign bus = bus_if.read ? out_reg : {BUS_WIDTH{1'bz}};

`ifdef PARALLEL_BUS_ERROR_COUNT_EN
    logic        seq_error;
    logic [31:0] errors;

    assign seq_error = addr_done && ((wword != D_LAST) || (rword != D_LAST));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            errors <= '0;
        end else if (seq_error) begin
            errors <= errors + 32'd1;
        end
    end

    assign error_led = |errors;
`else
    assign error_led = 1'b0;
`endif

    assign leds = {ack_q, write_strobe, error_led, ~reset_n, rs_s, rd_s, en_s, init};

endmodule

// File: tb/tb_parallel_bus_pollable_memory.sv
module tb_parallel_bus_pollable_memory;

    localparam int BW  = 8;
    localparam int TPD = 4;
    localparam int TPA = 2;
    localparam int AD  = 14;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    wire  [BW-1:0] bus;
    logic          m_drive = 1'b0;
    logic [BW-1:0] m_data = '0;
    logic [7:0]    leds;
    int            n_compared = 0;
    int            n_mismatched = 0;
    int            strobe_cnt = 0;

    parallel_bus_pollable_memory_if bif ();

    assign bus = m_drive ? m_data : {BW{1'bz}};

    parallel_bus_pollable_memory #(
        .BUS_WIDTH                    (BW),
        .TRANSACTIONS_PER_DATA_WORD   (TPD),
        .TRANSACTIONS_PER_ADDRESS_WORD(TPA),
        .ADDRESS_DEPTH                (AD)
    ) dut (
        .clock  (clock),
        .reset_n(reset_n),
        .bus    (bus),
        .bus_if (bif),
        .leds   (leds)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (leds[6]) strobe_cnt++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic xfer(input logic rd, input logic rs, input logic [7:0] wdat,
                        output logic [7:0] rdat);
        int t;
        @(negedge clock);
        bif.read            = rd;
        bif.register_select = rs;
        m_data              = wdat;
        m_drive             = !rd;
        #2 bif.enable = 1'b1;
        t = 0;
        while (bif.ack_valid !== 1'b1 && t < 100) begin
            @(negedge clock);
            t++;
        end
        check_eq("ack_rise", {31'd0, bif.ack_valid}, 32'd1);
        rdat = bus;
        bif.enable = 1'b0;
        t = 0;
        while (bif.ack_valid !== 1'b0 && t < 100) begin
            @(negedge clock);
            t++;
        end
        check_eq("ack_fall", {31'd0, bif.ack_valid}, 32'd0);
        m_drive  = 1'b0;
        bif.read = 1'b0;
    endtask

    task automatic write_addr(input logic [15:0] a);
        logic [7:0] dummy;
        xfer(1'b0, 1'b0, a[15:8], dummy);
        xfer(1'b0, 1'b0, a[7:0], dummy);
    endtask

    task automatic write_word(input logic [31:0] d);
        logic [7:0] dummy;
        for (int i = 0; i < TPD; i++) xfer(1'b0, 1'b1, d[31-8*i -: 8], dummy);
    endtask

    task automatic read_word(output logic [31:0] d);
        logic [7:0] c;
        d = '0;
        for (int i = 0; i < TPD; i++) begin
            xfer(1'b1, 1'b0, 8'h00, c);
            d = {d[23:0], c};
        end
    endtask

    task automatic check_init_release();
        repeat (8) @(posedge clock);
        #1 check_eq("init_hold", {31'd0, leds[0]}, 32'd1);
        @(posedge clock);
        #1 check_eq("init_done", {31'd0, leds[0]}, 32'd0);
    endtask

    logic [15:0] addr_tab [4] = '{16'hab4c, 16'hab4d, 16'hab4e, 16'hab4f};
    logic [31:0] data_tab [4] = '{32'h31232a12, 32'h31232b34, 32'h31232c56, 32'h31232d78};

    initial begin
        logic [31:0] rw;
        logic [7:0]  dummy;
        int          s0;
        int          t;

        bif.read            = 1'b0;
        bif.register_select = 1'b0;
        bif.enable          = 1'b0;

        repeat (3) @(negedge clock);
        check_eq("rst_ack",   {31'd0, bif.ack_valid}, 32'd0);
        check_eq("rst_init",  {31'd0, leds[0]}, 32'd1);
        check_eq("rst_led4",  {31'd0, leds[4]}, 32'd1);
        check_eq("rst_strobe", {31'd0, leds[6]}, 32'd0);
        reset_n = 1'b1;
        check_init_release();
        check_eq("led4_run", {31'd0, leds[4]}, 32'd0);

        // first word chunk by chunk, single strobe after the last chunk
        write_addr(16'hab4c);
        s0 = strobe_cnt;
        for (int i = 0; i < 3; i++) xfer(1'b0, 1'b1, data_tab[0][31-8*i -: 8], dummy);
        check_eq("strobe_pre", strobe_cnt - s0, 32'd0);
        xfer(1'b0, 1'b1, data_tab[0][7:0], dummy);
        check_eq("strobe_one", strobe_cnt - s0, 32'd1);
        read_word(rw);
        check_eq("rd_ab4c_first", rw, 32'h31232a12);

        for (int i = 1; i < 4; i++) begin
            write_addr(addr_tab[i]);
            write_word(data_tab[i]);
        end
        for (int i = 0; i < 4; i++) begin
            write_addr(addr_tab[i]);
            read_word(rw);
            check_eq($sformatf("rd_%h", addr_tab[i]), rw, data_tab[i]);
        end

        write_addr(16'h1234);
        write_word(32'h31231507);
        write_addr(16'h3412);
        write_word(32'h00001507);
        write_addr(16'h1234);
        read_word(rw);
        check_eq("rd_1234", rw, 32'h31231507);
        write_addr(16'h3412);
        read_word(rw);
        check_eq("rd_3412", rw, 32'h00001507);

        // 0x2b4c and 0xab4c share the low 14 bits
        write_addr(16'h2b4c);
        read_word(rw);
        check_eq("rd_alias", rw, 32'h31232a12);
        read_word(rw);
        check_eq("rd_reread", rw, 32'h31232a12);

        // abandoned data word followed by a fresh address
        write_addr(16'h0010);
        s0 = strobe_cnt;
        xfer(1'b0, 1'b1, 8'h99, dummy);
        xfer(1'b0, 1'b1, 8'h88, dummy);
        write_addr(16'h0020);
        repeat (2) @(negedge clock);
`ifdef PARALLEL_BUS_ERROR_COUNT_EN
        check_eq("err_led", {31'd0, leds[5]}, 32'd1);
`else
        check_eq("err_led", {31'd0, leds[5]}, 32'd0);
`endif
        check_eq("strobe_partial", strobe_cnt - s0, 32'd0);
        write_word(32'hdeadbeef);
        read_word(rw);
        check_eq("rd_after_abort", rw, 32'hdeadbeef);

        // reset in the middle of a data word
        write_addr(16'h0100);
        xfer(1'b0, 1'b1, 8'h55, dummy);
        xfer(1'b0, 1'b1, 8'h66, dummy);
        @(negedge clock);
        bif.register_select = 1'b1;
        m_data  = 8'h77;
        m_drive = 1'b1;
        #2 bif.enable = 1'b1;
        t = 0;
        while (bif.ack_valid !== 1'b1 && t < 100) begin
            @(negedge clock);
            t++;
        end
        check_eq("mid_ack_rise", {31'd0, bif.ack_valid}, 32'd1);
        #2 reset_n = 1'b0;
        #1 check_eq("mid_rst_ack", {31'd0, bif.ack_valid}, 32'd0);
        check_eq("mid_rst_init", {31'd0, leds[0]}, 32'd1);
        bif.enable = 1'b0;
        m_drive    = 1'b0;
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        check_init_release();
        write_addr(16'h0100);
        write_word(32'ha5c30f96);
        read_word(rw);
        check_eq("rd_after_rst", rw, 32'ha5c30f96);
        write_addr(16'h1234);
        read_word(rw);
        check_eq("ram_kept", rw, 32'h31231507);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
